pc_sequencer: RTL
=================

# pc_sequencer

Program-counter stage of the single-cycle/pipelined MIPS datapath. Holds the PC register and computes sequential, branch and jump successors. It selects the next PC with the same 2-bit encoding the 32-bit 3:1 datapath mux uses: 00 → in1, 01 → in2, 10 → in3. It feeds the instruction memory and the PC+4 input of the downstream branch/jump muxes, and flags the bubble cycle that follows every redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset; must be word-aligned.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freeze PC and state this cycle.
- pc_sel  input  2  next-PC select: 00 sequential (PC+4), 01 branch, 10 jump, 11 illegal.
- branch_offset  input  32  sign-extended word offset from the decoded instruction.
- jump_index  input  26  J-type target index.
- pc_out  output  32  current PC, registered.
- pc_plus4  output  32  pc_out + 4, combinational.
- instr_valid  output  1  1 = instruction fetched at pc_out is real; 0 = bubble.
- redirect_count  output  CNT_W  number of accepted branches and jumps, saturating.
- err  output  1  sticky illegal-select flag.

## Operation
- Branch target = pc_plus4 + (branch_offset << 2), 32-bit wraparound, no overflow detection.
- Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
- A cycle is "accepted" when reset=0 and stall=0.
- States:
  - BOOT: entered on reset.
  - RUN: normal fetch.
  - FLUSH: one bubble after a redirect.
- BOOT: instr_valid=0. The PC holds RESET_PC. The first accepted cycle moves to RUN without changing the PC, so the first real fetch is RESET_PC.
- RUN, accepted cycle:
  - pc_sel 00: pc ← pc_plus4; stay in RUN.
  - pc_sel 01: pc ← branch target; go to FLUSH; redirect_count increments.
  - pc_sel 10: pc ← jump target; go to FLUSH; redirect_count increments.
  - pc_sel 11: pc holds; err ← 1; stay in RUN. No increment.
- FLUSH: instr_valid=0. pc_sel is ignored and forced to 00, because it comes from the squashed instruction. The first accepted cycle does pc ← pc_plus4 and returns to RUN.
- Stall: pc, state, counter and err all hold. Stall has priority over any pc_sel value, so a redirect presented during a stall is not taken.
- redirect_count saturates at all-ones and does not wrap.
- err is cleared only by reset.
- Reset mid-operation: a pending redirect, FLUSH state and the counter are discarded on the next edge; reset overrides stall.

## Timing
- Reset values:
  - pc_out = RESET_PC
  - instr_valid = 0
  - redirect_count = 0
  - err = 0
  - state = BOOT
  - pc_plus4 = RESET_PC + 4
- All state updates on the rising edge of clk.
- pc_out changes one cycle after an accepted select. There is no extra pipeline latency.
- instr_valid is decoded from the registered state; it does not depend combinationally on the inputs.
- Redirect penalty: exactly 1 bubble cycle per accepted branch or jump, extended by any stall cycles spent in FLUSH.
- Back-to-back redirects cannot occur, because FLUSH ignores pc_sel.
- Combinational paths: pc_sel, branch_offset and jump_index feed only the D input of the PC register. pc_plus4 depends only on pc_out.

## Test plan
- Reset then 3 cycles of pc_sel=00, RESET_PC=0 → pc_out sequence 0,0,4,8; instr_valid sequence 0,1,1,1.
- At pc_out=0x100, pc_sel=01 with branch_offset=0xFFFF_FFFE:
  - next pc_out = 0x0FC, instr_valid=0, redirect_count=1.
  - Following cycle: pc_out=0x100, instr_valid=1, even with pc_sel=10 driven during FLUSH.
- At pc_out=0x4000_0010, pc_sel=10, jump_index=26'h0000_040 → pc_out=0x4000_0100; one bubble; redirect_count increments.
- stall=1 for 2 cycles with pc_sel=01 held → pc_out, state and redirect_count unchanged. On release, the branch is taken in the first cycle with stall=0.
- pc_sel=11 at pc_out=0x20 → pc_out stays 0x20, err=1 and stays 1 through later cycles until reset.
- Counter saturation, with CNT_W=2: 5 redirects → redirect_count stops at 3. Assert reset while in FLUSH → next cycle pc_out=RESET_PC, state BOOT, err=0, count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage of the MIPS datapath.
// Holds the PC, computes sequential/branch/jump successors and flags the
// single bubble cycle that follows each accepted redirect.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset (overrides stall)
//   stall          freeze PC, state, counter and err this cycle
//   pc_sel         next-PC select: 00 PC+4, 01 branch, 10 jump, 11 illegal
//   branch_offset  sign-extended word offset
//   jump_index     J-type target index
//   pc_out         current PC (registered)
//   pc_plus4       pc_out + 4 (combinational, depends only on pc_out)
//   instr_valid    1 = fetch at pc_out is real, 0 = bubble (registered)
//   redirect_count saturating count of accepted branches and jumps
//   err            sticky illegal-select flag, cleared only by reset
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       pc_sel,
  input  logic [31:0]      branch_offset,
  input  logic [25:0]      jump_index,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             instr_valid,
  output logic [CNT_W-1:0] redirect_count,
  output logic             err
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t      state;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4      = pc_out + 32'd4;
  assign branch_target = pc_plus4 + (branch_offset << 2);
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      pc_out         <= RESET_PC;
      instr_valid    <= 1'b0;
      redirect_count <= '0;
      err            <= 1'b0;
    end else if (!stall) begin
      case (state)
        // Leaving BOOT keeps the PC so the first real fetch is RESET_PC.
        BOOT: begin
          state       <= RUN;
          instr_valid <= 1'b1;
        end
        RUN: begin
          case (pc_sel)
            2'b00: pc_out <= pc_plus4;
            2'b01: begin
              pc_out      <= branch_target;
              state       <= FLUSH;
              instr_valid <= 1'b0;
              if (redirect_count != '1)
                redirect_count <= redirect_count + CNT_W'(1);
            end
            2'b10: begin
              pc_out      <= jump_target;
              state       <= FLUSH;
              instr_valid <= 1'b0;
              if (redirect_count != '1)
                redirect_count <= redirect_count + CNT_W'(1);
            end
            default: err <= 1'b1;
          endcase
        end
        // pc_sel belongs to the squashed instruction here, so it is ignored.
        FLUSH: begin
          pc_out      <= pc_plus4;
          state       <= RUN;
          instr_valid <= 1'b1;
        end
        default: begin
          state       <= BOOT;
          pc_out      <= RESET_PC;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
